tow_referee: RTL and testbench

//  Tug-of-war round referee; sits directly downstream of the push-button latch stage.
//  - Consumes that stage's push/tie/right flags, moves the rope-position marker one

---
 rtl/tow_referee.sv | 119 +++++++++++
 tb/tb_tow_referee.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_referee.sv
// Tug-of-war referee: moves the rope marker one step per latched press, detects
// round wins, keeps saturating round scores and re-arms the latch stage via clr.
module tow_referee #(
  parameter int HALF    = 3,
  parameter int CLR_MIN = 2,
  parameter int SCORE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 tie,
  input  logic                 right,
  output logic                 clr,
  output logic [2*HALF:0]      leds,
  output logic                 win_left,
  output logic                 win_right,
  output logic [SCORE_W-1:0]   score_left,
  output logic [SCORE_W-1:0]   score_right
);

  localparam int PW = $clog2(HALF + 1) + 1;
  localparam int CW = $clog2(CLR_MIN + 1) + 1;
  localparam logic signed [PW-1:0] P_MAX = PW'(HALF);
  localparam logic signed [PW-1:0] P_MIN = -P_MAX;

  typedef enum logic [1:0] {IDLE, DECIDE, RELEASE, WIN} state_t;

  state_t                   state_reg;
  logic signed [PW-1:0]     pos_reg;
  logic signed [PW-1:0]     pos_next;
  logic [CW-1:0]            cnt_reg;
  logic                     ack_reg;
  logic                     clr_reg;
  logic                     win_left_reg;
  logic                     win_right_reg;
  logic [SCORE_W-1:0]       score_left_reg;
  logic [SCORE_W-1:0]       score_right_reg;

  always_comb begin
    pos_next = pos_reg;
    if (!tie) begin
      if (right) pos_next = pos_reg + PW'(1);
      else       pos_next = pos_reg - PW'(1);
    end
  end

  // pos is always within -HALF..+HALF, so exactly one LED matches
  generate
    for (genvar gi = 0; gi <= 2*HALF; gi++) begin : g_led
      localparam logic signed [PW-1:0] LED_POS = PW'(gi - HALF);
      assign leds[gi] = (pos_reg == LED_POS);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      pos_reg         <= '0;
      cnt_reg         <= '0;
      ack_reg         <= 1'b0;
      clr_reg         <= 1'b0;
      win_left_reg    <= 1'b0;
      win_right_reg   <= 1'b0;
      score_left_reg  <= '0;
      score_right_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (push) state_reg <= DECIDE;
        end
        DECIDE: begin
          pos_reg <= pos_next;
          cnt_reg <= CW'(1);
          ack_reg <= 1'b0;
          clr_reg <= 1'b1;
          if (pos_next == P_MAX) begin
            state_reg     <= WIN;
            win_right_reg <= 1'b1;
            if (score_right_reg != '1) score_right_reg <= score_right_reg + 1'b1;
          end else if (pos_next == P_MIN) begin
            state_reg    <= WIN;
            win_left_reg <= 1'b1;
            if (score_left_reg != '1) score_left_reg <= score_left_reg + 1'b1;
          end else begin
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          // cnt_reg counts clr-high cycles completed, including the current one
          if (cnt_reg >= CW'(CLR_MIN) && !push) begin
            state_reg <= IDLE;
            clr_reg   <= 1'b0;
          end else if (cnt_reg < CW'(CLR_MIN)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WIN: begin
          if (push) begin
            ack_reg <= 1'b1;
          end else if (ack_reg) begin
            state_reg     <= IDLE;
            pos_reg       <= '0;
            clr_reg       <= 1'b0;
            win_left_reg  <= 1'b0;
            win_right_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign clr         = clr_reg;
  assign win_left    = win_left_reg;
  assign win_right   = win_right_reg;
  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;

endmodule

// File: tb/tb_tow_referee.sv
// Bench for tow_referee: directed scenarios plus random presses checked against
// a position/score model built from the round rules.
module tb_tow_referee;
  localparam int HALF    = 3;
  localparam int CLR_MIN = 2;
  localparam int SMAX    = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       tie = 1'b0;
  logic       right = 1'b0;
  logic       clr;
  logic [6:0] leds;
  logic       win_left;
  logic       win_right;
  logic [3:0] score_left;
  logic [3:0] score_right;

  int tests = 0;
  int fails = 0;
  int mpos = 0;
  int msl = 0;
  int msr = 0;

  tow_referee #(.HALF(HALF), .CLR_MIN(CLR_MIN), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
    .clr(clr), .leds(leds), .win_left(win_left), .win_right(win_right),
    .score_left(score_left), .score_right(score_right)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_leds(input int p);
    logic [6:0] one;
    one = 7'd1;
    return one << (HALF + p);
  endfunction

  // One press event: push held for 'hold' cycles starting at the drive edge.
  task automatic press(input bit t, input bit r, input int hold_in, input string tag);
    int np;
    bit w;
    int hold;
    int idx;
    int n;
    int exp_n;
    logic [6:0] old_leds;
    hold = hold_in;
    np = mpos;
    if (!t) np += r ? 1 : -1;
    w = (np == HALF) || (np == -HALF);
    if (w && hold > 2) hold = 2;
    old_leds = exp_leds(mpos);
    push = 1'b1; tie = t; right = r;
    @(negedge clk);
    if (hold <= 1) push = 1'b0;
    tests++;
    if (clr !== 1'b0 || leds !== old_leds) begin
      fails++;
      $display("FAIL %s decide: clr=%b leds=%b, required clr=0 leds=%b", tag, clr, leds, old_leds);
    end
    @(negedge clk);
    if (hold <= 2) push = 1'b0;
    mpos = np;
    if (w) begin
      if (np > 0) msr = (msr < SMAX) ? msr + 1 : SMAX;
      else        msl = (msl < SMAX) ? msl + 1 : SMAX;
    end
    tests++;
    if (leds !== exp_leds(mpos) || clr !== 1'b1 || win_right !== (w && np > 0) ||
        win_left !== (w && np < 0) || score_right !== 4'(msr) || score_left !== 4'(msl)) begin
      fails++;
      $display("FAIL %s move: leds=%b clr=%b wl=%b wr=%b sl=%0d sr=%0d, required leds=%b clr=1 wl=%b wr=%b sl=%0d sr=%0d",
               tag, leds, clr, win_left, win_right, score_left, score_right,
               exp_leds(mpos), w && np < 0, w && np > 0, msl, msr);
    end
    if (w) begin
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (clr !== 1'b1 || leds !== exp_leds(mpos)) begin
        fails++;
        $display("FAIL %s win_hold: clr=%b leds=%b, required clr=1 leds=%b", tag, clr, leds, exp_leds(mpos));
      end
      push = 1'b1;
      @(negedge clk);
      push = 1'b0;
      @(negedge clk);
      mpos = 0;
      tests++;
      if (leds !== exp_leds(0) || clr !== 1'b0 || win_left !== 1'b0 || win_right !== 1'b0 ||
          score_right !== 4'(msr) || score_left !== 4'(msl)) begin
        fails++;
        $display("FAIL %s ack: leds=%b clr=%b wl=%b wr=%b sl=%0d sr=%0d, required leds=%b clr=0 wl=0 wr=0 sl=%0d sr=%0d",
                 tag, leds, clr, win_left, win_right, score_left, score_right, exp_leds(0), msl, msr);
      end
    end else begin
      idx = 2;
      n = 1;
      forever begin
        if (idx >= hold) push = 1'b0;
        @(negedge clk);
        idx++;
        if (clr === 1'b1) n++;
        else break;
        if (n > 200) break;
      end
      exp_n = (hold - 1 > CLR_MIN) ? hold - 1 : CLR_MIN;
      tests++;
      if (n !== exp_n || leds !== exp_leds(mpos)) begin
        fails++;
        $display("FAIL %s clr_len: clr cycles=%0d leds=%b, required cycles=%0d leds=%b", tag, n, leds, exp_n, exp_leds(mpos));
      end
    end
    push = 1'b0; tie = 1'b0; right = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mpos = 0; msl = 0; msr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (leds !== 7'b0001000 || clr !== 1'b0 || win_left !== 1'b0 || win_right !== 1'b0 ||
        score_left !== 4'd0 || score_right !== 4'd0) begin
      fails++;
      $display("FAIL reset: leds=%b clr=%b wl=%b wr=%b sl=%0d sr=%0d, required 0001000 0 0 0 0 0",
               leds, clr, win_left, win_right, score_left, score_right);
    end
  endtask

  task automatic test_right_press();
    press(1'b0, 1'b1, 1, "right_press");
    tests++;
    if (leds !== 7'b0010000) begin
      fails++;
      $display("FAIL right_press_leds: leds=%b, required 0010000", leds);
    end
    press(1'b0, 1'b0, 2, "left_back");
  endtask

  task automatic test_tie();
    press(1'b1, 1'b0, 1, "tie_centre");
    press(1'b1, 1'b1, 3, "tie_right_flag");
    tests++;
    if (leds !== 7'b0001000 || win_left !== 1'b0 || win_right !== 1'b0) begin
      fails++;
      $display("FAIL tie_state: leds=%b wl=%b wr=%b, required 0001000 0 0", leds, win_left, win_right);
    end
  endtask

  task automatic test_win_right();
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1, "win_right");
    tests++;
    if (score_right !== 4'd1 || leds !== 7'b0001000) begin
      fails++;
      $display("FAIL win_right_score: sr=%0d leds=%b, required 1 0001000", score_right, leds);
    end
  endtask

  task automatic test_held();
    press(1'b0, 1'b1, 20, "held_20");
    tests++;
    if (leds !== 7'b0010000) begin
      fails++;
      $display("FAIL held_one_move: leds=%b, required 0010000", leds);
    end
    press(1'b0, 1'b0, 5, "held_back");
  endtask

  task automatic test_tie_near_edge();
    press(1'b0, 1'b0, 1, "near_l1");
    press(1'b0, 1'b0, 1, "near_l2");
    press(1'b1, 1'b0, 1, "near_tie");
    tests++;
    if (leds !== 7'b0000010 || win_left !== 1'b0) begin
      fails++;
      $display("FAIL tie_near_edge: leds=%b wl=%b, required 0000010 0", leds, win_left);
    end
    press(1'b0, 1'b0, 1, "near_win");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int rd = 0; rd < 16; rd++)
      for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1, "sat_left");
    tests++;
    if (score_left !== 4'd15 || score_right !== 4'd0) begin
      fails++;
      $display("FAIL saturation: sl=%0d sr=%0d, required 15 0", score_left, score_right);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      press(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), "random");
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    for (int rd = 0; rd < 3; rd++)
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1, "mid_setup_win");
    press(1'b0, 1'b1, 1, "mid_setup_p1");
    push = 1'b1; right = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (leds !== 7'b0100000 || clr !== 1'b1 || score_right !== 4'd3) begin
      fails++;
      $display("FAIL mid_pre: leds=%b clr=%b sr=%0d, required 0100000 1 3", leds, clr, score_right);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; push = 1'b0; right = 1'b0;
    mpos = 0; msl = 0; msr = 0;
    tests++;
    if (leds !== 7'b0001000 || clr !== 1'b0 || score_right !== 4'd0 || score_left !== 4'd0 ||
        win_right !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: leds=%b clr=%b sl=%0d sr=%0d wr=%b, required 0001000 0 0 0 0",
               leds, clr, score_left, score_right, win_right);
    end
    press(1'b0, 1'b1, 1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_right_press();
    test_tie();
    test_win_right();
    test_held();
    test_tie_near_edge();
    test_random();
    test_saturation();
    test_reset_mid_release();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
